// File: rtl/msrv32_pkg.sv
// Shared MSRV32 definitions: load/store unit FSM encoding, access size codes
// and the default data-bus timeout.
package msrv32_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_BUSY = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_e;

  localparam logic [1:0] LS_BYTE = 2'b00;
  localparam logic [1:0] LS_HALF = 2'b01;
  localparam logic [1:0] LS_WORD = 2'b10;

  localparam int unsigned LSU_TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/msrv32_lsu_if.sv
// Data-memory request/acknowledge bus between the load/store unit (master)
// and the data memory (slave).
interface msrv32_lsu_if;

  logic [31:0] dmem_addr_out;
  logic [31:0] dmem_wr_data_out;
  logic [3:0]  dmem_wr_mask_out;
  logic        dmem_wr_req_out;
  logic        dmem_rd_req_out;
  logic        dmem_ack_in;
  logic        dmem_err_in;
  logic [31:0] dmem_rd_data_in;

  modport master (
    output dmem_addr_out, dmem_wr_data_out, dmem_wr_mask_out,
           dmem_wr_req_out, dmem_rd_req_out,
    input  dmem_ack_in, dmem_err_in, dmem_rd_data_in
  );

  modport slave (
    input  dmem_addr_out, dmem_wr_data_out, dmem_wr_mask_out,
           dmem_wr_req_out, dmem_rd_req_out,
    output dmem_ack_in, dmem_err_in, dmem_rd_data_in
  );

endinterface

// File: rtl/msrv32_lsu_align.sv
// Byte-lane steering for stores and lane extraction plus sign/zero extension
// for loads; purely combinational, shared by both directions.
module msrv32_lsu_align
  import msrv32_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] rd_data_i,
  output logic [31:0] wr_data_o,
  output logic [3:0]  wr_mask_o,
  output logic [31:0] ld_data_o
);

  logic        sext;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    sext      = ~unsigned_i;
    byte_v    = rd_data_i[{addr_lo_i, 3'b000} +: 8];
    half_v    = rd_data_i[{addr_lo_i[1], 4'b0000} +: 16];
    wr_mask_o = 4'b1111;
    wr_data_o = st_data_i;
    ld_data_o = rd_data_i;
    case (size_i)
      LS_BYTE: begin
        wr_mask_o = 4'b0001 << addr_lo_i;
        wr_data_o = {4{st_data_i[7:0]}};
        ld_data_o = {{24{sext & byte_v[7]}}, byte_v};
      end
      LS_HALF: begin
        wr_mask_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wr_data_o = {2{st_data_i[15:0]}};
        ld_data_o = {{16{sext & half_v[15]}}, half_v};
      end
      default: begin
        wr_mask_o = 4'b1111;
        wr_data_o = st_data_i;
        ld_data_o = rd_data_i;
      end
    endcase
  end

endmodule

// File: rtl/msrv32_lsu.sv
// MSRV32 load/store unit: captures one decoded memory request, runs it on the
// data bus with a timeout, and stalls the pipeline until it retires.
module msrv32_lsu
  import msrv32_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
  input  logic               ms_riscv32_mp_clk_in,
  input  logic               ms_riscv32_mp_rst_in,
  input  logic               mem_wr_req_in,
  input  logic               mem_rd_req_in,
  input  logic [1:0]         load_size_in,
  input  logic               load_unsigned_in,
  input  logic [31:0]        iadder_out_in,
  input  logic [31:0]        rs2_in,
  msrv32_lsu_if.master       dmem,
  output logic               stall_out,
  output logic [31:0]        load_data_out,
  output logic               load_valid_out,
  output logic               bus_fault_out,
  output logic [31:0]        fault_addr_out
);

  localparam logic [7:0] TO_INIT = 8'(TIMEOUT_CYCLES);

  lsu_state_e  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic [3:0]  mask_q, mask_d;
  logic        wr_req_q, wr_req_d;
  logic        rd_req_q, rd_req_d;
  logic [31:0] load_data_q, load_data_d;
  logic        load_valid_q, load_valid_d;
  logic        bus_fault_q, bus_fault_d;
  logic [31:0] fault_addr_q, fault_addr_d;

  logic        req_any;
  logic        in_busy;
  logic        fault;
  logic [1:0]  al_size;
  logic        al_uns;
  logic [1:0]  al_addr_lo;
  logic [31:0] al_wr_data;
  logic [3:0]  al_wr_mask;
  logic [31:0] al_ld_data;

  assign req_any = mem_wr_req_in | mem_rd_req_in;
  assign in_busy = (state_q == LSU_BUSY);

  // In IDLE the aligner steers the incoming store; in BUSY it extracts the
  // returning load using the captured size/offset.
  assign al_size    = in_busy ? size_q : load_size_in;
  assign al_uns     = in_busy ? uns_q : load_unsigned_in;
  assign al_addr_lo = in_busy ? addr_q[1:0] : iadder_out_in[1:0];

  msrv32_lsu_align u_align (
    .size_i     (al_size),
    .unsigned_i (al_uns),
    .addr_lo_i  (al_addr_lo),
    .st_data_i  (rs2_in),
    .rd_data_i  (dmem.dmem_rd_data_in),
    .wr_data_o  (al_wr_data),
    .wr_mask_o  (al_wr_mask),
    .ld_data_o  (al_ld_data)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    size_d       = size_q;
    uns_d        = uns_q;
    wr_data_d    = wr_data_q;
    mask_d       = mask_q;
    wr_req_d     = wr_req_q;
    rd_req_d     = rd_req_q;
    load_data_d  = load_data_q;
    fault_addr_d = fault_addr_q;
    load_valid_d = 1'b0;
    bus_fault_d  = 1'b0;
    fault        = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        if (req_any) begin
          state_d   = LSU_BUSY;
          cnt_d     = TO_INIT;
          addr_d    = iadder_out_in;
          size_d    = load_size_in;
          uns_d     = load_unsigned_in;
          wr_data_d = al_wr_data;
          mask_d    = mem_wr_req_in ? al_wr_mask : 4'b0000;
          wr_req_d  = mem_wr_req_in;
          rd_req_d  = ~mem_wr_req_in & mem_rd_req_in;
        end
      end
      LSU_BUSY: begin
        // A count of 1 on an un-acked cycle is the last one allowed: the
        // decrement to zero is the timeout.
        if (dmem.dmem_err_in | dmem.dmem_ack_in | (cnt_q == 8'd1)) begin
          fault    = dmem.dmem_err_in | ~dmem.dmem_ack_in;
          state_d  = LSU_DONE;
          wr_req_d = 1'b0;
          rd_req_d = 1'b0;
          if (fault) begin
            bus_fault_d  = 1'b1;
            fault_addr_d = addr_q;
            if (rd_req_q) load_data_d = 32'd0;
          end else if (rd_req_q) begin
            load_data_d  = al_ld_data;
            load_valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state_q      <= LSU_IDLE;
      cnt_q        <= 8'd0;
      addr_q       <= 32'd0;
      size_q       <= LS_BYTE;
      uns_q        <= 1'b0;
      wr_data_q    <= 32'd0;
      mask_q       <= 4'd0;
      wr_req_q     <= 1'b0;
      rd_req_q     <= 1'b0;
      load_data_q  <= 32'd0;
      load_valid_q <= 1'b0;
      bus_fault_q  <= 1'b0;
      fault_addr_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      wr_data_q    <= wr_data_d;
      mask_q       <= mask_d;
      wr_req_q     <= wr_req_d;
      rd_req_q     <= rd_req_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      bus_fault_q  <= bus_fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign dmem.dmem_addr_out    = {addr_q[31:2], 2'b00};
  assign dmem.dmem_wr_data_out = wr_data_q;
  assign dmem.dmem_wr_mask_out = mask_q;
  assign dmem.dmem_wr_req_out  = wr_req_q;
  assign dmem.dmem_rd_req_out  = rd_req_q;

  assign stall_out      = ((state_q == LSU_IDLE) & req_any) | in_busy;
  assign load_data_out  = load_data_q;
  assign load_valid_out = load_valid_q;
  assign bus_fault_out  = bus_fault_q;
  assign fault_addr_out = fault_addr_q;

endmodule

// File: tb/tb_msrv32_lsu.sv
// Bench for msrv32_lsu: directed vector table, reset/ack corner sequences and
// randomized transactions against an arithmetic reference model.
module tb_msrv32_lsu;
  import msrv32_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_req, rd_req, uns;
  logic [1:0]  size;
  logic [31:0] addr, rs2;
  logic        stall, lvalid, bfault;
  logic [31:0] ldata, faddr;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_last = 32'd0;

  always #5 clk = ~clk;

  msrv32_lsu_if bus ();

  msrv32_lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst),
    .mem_wr_req_in        (wr_req),
    .mem_rd_req_in        (rd_req),
    .load_size_in         (size),
    .load_unsigned_in     (uns),
    .iadder_out_in        (addr),
    .rs2_in               (rs2),
    .dmem                 (bus),
    .stall_out            (stall),
    .load_data_out        (ldata),
    .load_valid_out       (lvalid),
    .bus_fault_out        (bfault),
    .fault_addr_out       (faddr)
  );

  // mode: 0 ack only, 1 err only, 2 err+ack together; waits>=TO means no response
  typedef struct {
    logic        wr;
    logic        rd;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [31:0] rdata;
    int          waits;
    int          mode;
    logic [3:0]  emask;
    logic [31:0] ewdata;
    logic [31:0] eld;
    logic        efault;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic void model_store(input logic [1:0] sz, input logic [31:0] a,
                                      input logic [31:0] d, output logic [3:0] m,
                                      output logic [31:0] w);
    int off;
    off = int'(a[1:0]);
    if (sz == 2'd0) begin
      m = 4'(1 << off);
      w = {24'd0, d[7:0]} * 32'h0101_0101;
    end else if (sz == 2'd1) begin
      m = (off >= 2) ? 4'hC : 4'h3;
      w = {16'd0, d[15:0]} * 32'h0001_0001;
    end else begin
      m = 4'hF;
      w = d;
    end
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic u,
                                             input logic [31:0] a, input logic [31:0] rd);
    longint v;
    int off;
    off = int'(a[1:0]);
    if (sz == 2'd0) begin
      v = longint'((rd >> (8 * off)) & 32'hFF);
      if (!u && v > 127) v = v - 256;
    end else if (sz == 2'd1) begin
      v = longint'((rd >> (16 * (off / 2))) & 32'hFFFF);
      if (!u && v > 32767) v = v - 65536;
    end else begin
      v = longint'(rd);
    end
    return v[31:0];
  endfunction

  task automatic do_txn(input vec_t v);
    logic ewr, erd;
    int   cyc, ebusy;
    bit   done;
    ewr = v.wr;
    erd = !v.wr && v.rd;
    wr_req = v.wr; rd_req = v.rd; size = v.size; uns = v.uns; addr = v.addr; rs2 = v.rs2;
    #1 chk("stall_t0", 32'(stall), 32'd1);
    @(posedge clk); @(negedge clk);
    chk("dmem_wr_req", 32'(bus.dmem_wr_req_out), 32'(ewr));
    chk("dmem_rd_req", 32'(bus.dmem_rd_req_out), 32'(erd));
    chk("dmem_addr", bus.dmem_addr_out, v.addr & 32'hFFFF_FFFC);
    if (ewr) begin
      chk("wr_mask", 32'(bus.dmem_wr_mask_out), 32'(v.emask));
      chk("wr_data", bus.dmem_wr_data_out, v.ewdata);
    end
    cyc = 0;
    done = 1'b0;
    while (!done && cyc <= TO + 2) begin
      if (cyc == v.waits) begin
        bus.dmem_ack_in = (v.mode != 1);
        bus.dmem_err_in = (v.mode != 0);
        bus.dmem_rd_data_in = v.rdata;
      end else begin
        bus.dmem_ack_in = 1'b0;
        bus.dmem_err_in = 1'b0;
        bus.dmem_rd_data_in = $urandom;
      end
      chk("busy_stall", 32'(stall), 32'd1);
      @(posedge clk); @(negedge clk);
      bus.dmem_ack_in = 1'b0;
      bus.dmem_err_in = 1'b0;
      cyc++;
      if (!stall) done = 1'b1;
    end
    if (!done) chk("retire_bound", 32'd0, 32'd1);
    ebusy = (v.waits < TO) ? v.waits + 1 : TO;
    chk("busy_cycles", 32'(cyc), 32'(ebusy));
    if (erd) exp_last = v.efault ? 32'd0 : v.eld;
    chk("load_valid", 32'(lvalid), 32'(erd && !v.efault));
    chk("bus_fault", 32'(bfault), 32'(v.efault));
    if (v.efault) chk("fault_addr", faddr, v.addr);
    chk("load_data", ldata, exp_last);
    chk("done_reqs", 32'({bus.dmem_wr_req_out, bus.dmem_rd_req_out}), 32'd0);
    // requests deliberately still high across the DONE cycle
    @(posedge clk); @(negedge clk);
    chk("no_relaunch", 32'({bus.dmem_wr_req_out, bus.dmem_rd_req_out}), 32'd0);
    chk("strobes_idle", 32'({lvalid, bfault}), 32'd0);
    wr_req = 1'b0; rd_req = 1'b0;
    #1 chk("idle_stall", 32'(stall), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vec_t r;
    rst = 1'b1;
    wr_req = 0; rd_req = 0; size = 0; uns = 0; addr = 0; rs2 = 0;
    bus.dmem_ack_in = 0; bus.dmem_err_in = 0; bus.dmem_rd_data_in = 0;

    tbl[0] = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h1003, 32'h0000_00A5, 32'h0, 0, 0, 4'b1000, 32'hA5A5_A5A5, 32'h0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h2002, 32'h0, 32'h8001_1234, 3, 0, 4'h0, 32'h0, 32'hFFFF_8001, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 2'b00, 1'b1, 32'h2001, 32'h0, 32'h0000_F200, 1, 0, 4'h0, 32'h0, 32'h0000_00F2, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h3006, 32'h0, 32'h1111_1111, 255, 0, 4'h0, 32'h0, 32'h0, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 2'b10, 1'b0, 32'h4000, 32'hDEAD_BEEF, 32'h2222_2222, 0, 2, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h5002, 32'h1234_ABCD, 32'h0, 2, 0, 4'b1100, 32'hABCD_ABCD, 32'h0, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 2'b11, 1'b0, 32'h6000, 32'h0, 32'h1234_5678, 0, 0, 4'h0, 32'h0, 32'h1234_5678, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h7003, 32'h0, 32'h80FF_FFFF, 0, 0, 4'h0, 32'h0, 32'hFFFF_FF80, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h8001, 32'h0, 32'h0000_5500, 2, 1, 4'h0, 32'h0, 32'h0, 1'b1};
    tbl[9] = '{1'b0, 1'b1, 2'b01, 1'b1, 32'h9000, 32'h0, 32'h0000_FFFE, 1, 0, 4'h0, 32'h0, 32'h0000_FFFE, 1'b0};

    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_reqs", 32'({bus.dmem_wr_req_out, bus.dmem_rd_req_out}), 32'd0);
    chk("rst_strobes", 32'({lvalid, bfault}), 32'd0);
    chk("rst_load_data", ldata, 32'd0);
    rst = 1'b0;

    // ack/err outside BUSY must not produce a strobe
    bus.dmem_ack_in = 1'b1; bus.dmem_err_in = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.dmem_ack_in = 1'b0; bus.dmem_err_in = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("stray_ack", 32'({lvalid, bfault, bus.dmem_wr_req_out, bus.dmem_rd_req_out}), 32'd0);

    for (int i = 0; i < 10; i++) do_txn(tbl[i]);

    // reset in the middle of a waiting load, then a late ack
    wr_req = 0; rd_req = 1; size = 2'b10; uns = 0; addr = 32'hA004; rs2 = 0;
    @(posedge clk); @(negedge clk);
    rd_req = 0;
    @(posedge clk); @(negedge clk);
    chk("pre_rst_busy", 32'(bus.dmem_rd_req_out), 32'd1);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("mid_rst_reqs", 32'({bus.dmem_wr_req_out, bus.dmem_rd_req_out}), 32'd0);
    chk("mid_rst_addr", bus.dmem_addr_out, 32'd0);
    chk("mid_rst_wdata", bus.dmem_wr_data_out, 32'd0);
    chk("mid_rst_mask", 32'(bus.dmem_wr_mask_out), 32'd0);
    chk("mid_rst_stall", 32'(stall), 32'd0);
    chk("mid_rst_ldata", ldata, 32'd0);
    chk("mid_rst_faddr", faddr, 32'd0);
    chk("mid_rst_strobes", 32'({lvalid, bfault}), 32'd0);
    rst = 1'b0;
    exp_last = 32'd0;
    bus.dmem_ack_in = 1'b1; bus.dmem_rd_data_in = 32'hCAFE_F00D;
    @(posedge clk); @(negedge clk);
    bus.dmem_ack_in = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("late_ack_strobes", 32'({lvalid, bfault}), 32'd0);
    chk("late_ack_stall", 32'(stall), 32'd0);
    chk("late_ack_ldata", ldata, 32'd0);

    for (int i = 0; i < 40; i++) begin
      r.wr    = 1'($urandom_range(0, 1));
      r.rd    = r.wr ? 1'($urandom_range(0, 1)) : 1'b1;
      r.size  = 2'($urandom_range(0, 3));
      r.uns   = 1'($urandom_range(0, 1));
      r.addr  = $urandom;
      r.rs2   = $urandom;
      r.rdata = $urandom;
      r.waits = $urandom_range(0, 5);
      r.mode  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0;
      model_store(r.size, r.addr, r.rs2, r.emask, r.ewdata);
      r.eld    = model_load(r.size, r.uns, r.addr, r.rdata);
      r.efault = (r.waits >= TO) || (r.mode != 0);
      do_txn(r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
